// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-request valid/ready port to APB3 initiator.
// One SETUP + ACCESS per request, with an optional ACCESS-phase timeout.
module apb_master_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              aclk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] M_APB_PADDR,
  output logic              M_APB_PSEL,
  output logic              M_APB_PENABLE,
  output logic              M_APB_PWRITE,
  output logic [DATA_W-1:0] M_APB_PWDATA,
  input  logic [DATA_W-1:0] M_APB_PRDATA,
  input  logic              M_APB_PREADY,
  input  logic              M_APB_PSLVERR
);

  localparam int CW =
    (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] LIMIT =
    TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_d;
  logic [ADDR_W-1:0] paddr_d;
  logic              psel_d;
  logic              penable_d;
  logic              pwrite_d;
  logic [DATA_W-1:0] pwdata_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              rsp_err_d;
  logic              rsp_timeout_d;

  // Gated by resetn so nothing is accepted while reset is held.
  assign req_ready = resetn && (state == IDLE);

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    paddr_d       = M_APB_PADDR;
    psel_d        = M_APB_PSEL;
    penable_d     = M_APB_PENABLE;
    pwrite_d      = M_APB_PWRITE;
    pwdata_d      = M_APB_PWDATA;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          paddr_d   = req_addr;
          pwrite_d  = req_write;
          if (req_write) begin
            pwdata_d = req_wdata;
          end
          psel_d    = 1'b1;
          penable_d = 1'b0;
          cnt_d     = '0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (M_APB_PREADY) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = M_APB_PWRITE ? '0 : M_APB_PRDATA;
          rsp_err_d     = M_APB_PSLVERR;
          rsp_timeout_d = 1'b0;
          state_d       = IDLE;
        end else if (TO_EN && (cnt == LIMIT)) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = IDLE;
        end else if (cnt != '1) begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      cnt           <= '0;
      M_APB_PADDR   <= '0;
      M_APB_PSEL    <= 1'b0;
      M_APB_PENABLE <= 1'b0;
      M_APB_PWRITE  <= 1'b0;
      M_APB_PWDATA  <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      rsp_timeout   <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      M_APB_PADDR   <= paddr_d;
      M_APB_PSEL    <= psel_d;
      M_APB_PENABLE <= penable_d;
      M_APB_PWRITE  <= pwrite_d;
      M_APB_PWDATA  <= pwdata_d;
      rsp_valid     <= rsp_valid_d;
      rsp_rdata     <= rsp_rdata_d;
      rsp_err       <= rsp_err_d;
      rsp_timeout   <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed requests, scoreboard queues for APB
// phases and responses, bus slave model with per-test wait states.
module tb_apb_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          write;
  } apb_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
    int            acc;
    int            lat;
  } rsp_t;

  logic          aclk = 1'b0;
  logic          resetn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  apb_master_bridge #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk),
    .resetn(resetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .M_APB_PADDR(paddr),
    .M_APB_PSEL(psel),
    .M_APB_PENABLE(penable),
    .M_APB_PWRITE(pwrite),
    .M_APB_PWDATA(pwdata),
    .M_APB_PRDATA(prdata),
    .M_APB_PREADY(pready),
    .M_APB_PSLVERR(pslverr)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int pass_n = 0;
  int total_n = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h @%0t",
                  name, act, exp, $time);
  endtask

  apb_t apbq[$];
  rsp_t rspq[$];

  // Slave model: PREADY rises on ACCESS cycle number wait_n (0-based).
  // Outside ACCESS it drives PREADY/PSLVERR high to prove they are ignored.
  logic [DW-1:0] mem [logic [AW-1:0]];
  int   wait_n = 0;
  logic slv_err = 1'b0;
  int   acc = 0;

  always @(negedge aclk) begin
    if (psel && penable) begin
      pready  = (acc == wait_n);
      pslverr = (acc == wait_n) && slv_err;
      prdata  = mem.exists(paddr) ? mem[paddr] : 32'hDEADBEEF;
      acc++;
    end else begin
      acc     = 0;
      pready  = 1'b1;
      pslverr = 1'b1;
      prdata  = 32'h5A5A5A5A;
    end
  end

  int psel_run = 0;
  int pen_run = 0;
  int last_psel = 0;
  int last_pen = 0;
  apb_t cur;

  always @(negedge aclk) begin
    if (!resetn) begin
      psel_run = 0;
      pen_run  = 0;
    end else if (psel) begin
      if (psel_run == 0) begin
        if (apbq.size() == 0) begin
          total_n++;
          $display("FAIL unexpected_psel: got 1 expected 0 @%0t", $time);
        end else begin
          cur = apbq.pop_front();
        end
        check("setup_penable", 64'(penable), 64'd0);
      end
      check("paddr", 64'(paddr), 64'(cur.addr));
      check("pwrite", 64'(pwrite), 64'(cur.write));
      check("pwdata", 64'(pwdata), 64'(cur.wdata));
      psel_run++;
      if (penable) pen_run++;
    end else begin
      if (psel_run != 0) begin
        last_psel = psel_run;
        last_pen  = pen_run;
      end
      check("idle_penable", 64'(penable), 64'd0);
      psel_run = 0;
      pen_run  = 0;
    end
  end

  int rsp_seen = 0;
  rsp_t er;

  always @(negedge aclk) begin
    if (rsp_valid) begin
      rsp_seen++;
      if (rspq.size() == 0) begin
        total_n++;
        $display("FAIL unexpected_rsp: got rsp_valid expected none @%0t",
                 $time);
      end else begin
        er = rspq.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(er.rdata));
        check("rsp_err", 64'(rsp_err), 64'(er.err));
        check("rsp_timeout", 64'(rsp_timeout), 64'(er.to));
        check("rsp_latency", 64'(cyc - er.acc), 64'(er.lat));
      end
    end
  end

  logic [DW-1:0] last_wdata = '0;

  task automatic issue(input logic wr,
                       input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata,
                       input logic [DW-1:0] exp_rdata,
                       input logic exp_err,
                       input logic exp_to,
                       input int lat,
                       input bit want_rsp,
                       input bit hold,
                       output int acc_cyc);
    apb_t a;
    rsp_t r;
    int n;
    a.addr  = addr;
    a.write = wr;
    a.wdata = wr ? wdata : last_wdata;
    if (wr) last_wdata = wdata;
    apbq.push_back(a);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wr ? wdata : 32'hBAD0BAD0;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (!req_ready) begin
      total_n++;
      $display("FAIL req_ready_wait: got 0 expected 1 @%0t", $time);
    end
    @(posedge aclk);
    #1;
    acc_cyc = cyc;
    if (!hold) req_valid = 1'b0;
    if (want_rsp) begin
      r.rdata = exp_rdata;
      r.err   = exp_err;
      r.to    = exp_to;
      r.acc   = acc_cyc;
      r.lat   = lat;
      rspq.push_back(r);
    end
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (rspq.size() != 0 && n < 40) begin
      @(negedge aclk);
      #1;
      n++;
    end
    if (rspq.size() != 0) begin
      total_n++;
      $display("FAIL rsp_wait: got %0d pending expected 0", rspq.size());
      rspq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int ac;
  int acs [4];
  int seen0;

  initial begin
    mem[32'h10] = 32'hAAABBBCC;
    mem[32'h30] = 32'h0BADF00D;
    mem[32'h34] = 32'h600DCAFE;
    mem[32'h44] = 32'h44445555;
    mem[32'h54] = 32'h22222222;
    mem[32'h5C] = 32'h44444444;

    // Reset held with a pending request.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h99;
    req_wdata = 32'h77;
    for (int i = 0; i < 7; i++) begin
      @(negedge aclk);
      check("reset_outs",
            64'({req_ready, psel, penable, pwrite, rsp_valid,
                 rsp_err, rsp_timeout}), 64'd0);
      check("reset_data", 64'(paddr | pwdata | rsp_rdata), 64'd0);
    end
    @(posedge aclk);
    #1;
    req_valid = 1'b0;
    resetn    = 1'b1;
    #1;
    check("ready_after_reset", 64'(req_ready), 64'd1);

    // Zero-wait read.
    wait_n = 0;
    issue(1'b0, 32'h10, '0, 32'hAAABBBCC, 1'b0, 1'b0, 2, 1, 0, ac);
    wait_rsp();
    check("zw_psel_cycles", 64'(last_psel), 64'd2);
    check("zw_pen_cycles", 64'(last_pen), 64'd1);
    @(negedge aclk);
    check("rsp_pulse", 64'(rsp_valid), 64'd0);
    check("rdata_hold", 64'(rsp_rdata), 64'hAAABBBCC);

    // Write with 3 wait states.
    wait_n = 3;
    issue(1'b1, 32'h24, 32'h12345678, '0, 1'b0, 1'b0, 5, 1, 0, ac);
    wait_rsp();
    check("ws_psel_cycles", 64'(last_psel), 64'd5);
    check("ws_pen_cycles", 64'(last_pen), 64'd4);

    // Slave error then clean read.
    wait_n  = 0;
    slv_err = 1'b1;
    issue(1'b0, 32'h30, '0, 32'h0BADF00D, 1'b1, 1'b0, 2, 1, 0, ac);
    wait_rsp();
    slv_err = 1'b0;
    issue(1'b0, 32'h34, '0, 32'h600DCAFE, 1'b0, 1'b0, 2, 1, 0, ac);
    wait_rsp();

    // Timeout after 8 ACCESS cycles.
    wait_n = 1000;
    issue(1'b0, 32'h40, '0, '0, 1'b1, 1'b1, 9, 1, 0, ac);
    wait_rsp();
    check("to_pen_cycles", 64'(last_pen), 64'd8);
    check("to_psel_cycles", 64'(last_psel), 64'd9);

    // PREADY on the 8th ACCESS cycle wins over the abort.
    wait_n = 7;
    issue(1'b0, 32'h44, '0, 32'h44445555, 1'b0, 1'b0, 9, 1, 0, ac);
    wait_rsp();
    check("late_pen_cycles", 64'(last_pen), 64'd8);

    // Back-to-back with req_valid held high.
    wait_n = 0;
    issue(1'b1, 32'h50, 32'h11111111, '0, 1'b0, 1'b0, 2, 1, 1, acs[0]);
    issue(1'b0, 32'h54, '0, 32'h22222222, 1'b0, 1'b0, 2, 1, 1, acs[1]);
    issue(1'b1, 32'h58, 32'h33333333, '0, 1'b0, 1'b0, 2, 1, 1, acs[2]);
    issue(1'b0, 32'h5C, '0, 32'h44444444, 1'b0, 1'b0, 2, 1, 0, acs[3]);
    wait_rsp();
    for (int i = 1; i < 4; i++)
      check("b2b_spacing", 64'(acs[i] - acs[i-1]), 64'd3);

    // Reset while in ACCESS: no response, PSEL drops at once.
    wait_n = 1000;
    issue(1'b0, 32'h60, '0, '0, 1'b0, 1'b0, 0, 0, 0, ac);
    @(posedge aclk);
    @(posedge aclk);
    #3;
    check("pre_reset_psel", 64'({psel, penable}), 64'd3);
    seen0  = rsp_seen;
    resetn = 1'b0;
    #1;
    check("async_psel_drop", 64'({psel, penable}), 64'd0);
    last_wdata = '0;
    repeat (2) @(posedge aclk);
    #1;
    resetn = 1'b1;
    repeat (12) @(negedge aclk);
    check("no_rsp_after_reset", 64'(rsp_seen - seen0), 64'd0);

    // Recovery transfer; PWDATA is back to its reset value.
    wait_n = 0;
    issue(1'b0, 32'h10, '0, 32'hAAABBBCC, 1'b0, 1'b0, 2, 1, 0, ac);
    wait_rsp();

    repeat (3) @(negedge aclk);
    check("apbq_empty", 64'(apbq.size()), 64'd0);
    check("rspq_empty", 64'(rspq.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
